// File: rtl/ifu_exu_ibuf_pkg.sv
// ifu_exu_ibuf_pkg: shared widths, buffer defaults and rv32 length pre-decode
package ifu_exu_ibuf_pkg;
  localparam int PC_SIZE = 32;
  localparam int XLEN = 32;
  localparam int IBUF_DEPTH = 2;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  function automatic logic is_rv32(input logic [1:0] lo);
    return lo == 2'b11;
  endfunction
endpackage

// File: rtl/ifu_exu_ibuf_entry_mem.sv
// ifu_exu_ibuf_entry_mem: DEPTH x W register array, one write port, async read port
module ifu_exu_ibuf_entry_mem #(
  parameter int DEPTH = 2,
  parameter int W = 64,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  // next array contents: only the addressed entry changes on a write
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end
  // entries are cleared on reset so the read port never shows X
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_q <= '{default: '0};
    else mem_q <= mem_d;
  end
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/ifu_exu_ibuf.sv
// ifu_exu_ibuf: IFU->EXU instruction FIFO with flush and rv32 pre-decode; IFU_EXU_IBUF_BYPASS_EN adds an empty-buffer pass-through
module ifu_exu_ibuf
  import ifu_exu_ibuf_pkg::*;
#(
  parameter int DEPTH = IBUF_DEPTH,
  parameter int PC_W = PC_SIZE,
  parameter int IR_W = XLEN,
  parameter logic [IR_W-1:0] NOP_IR = IR_W'(NOP_INSTR)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ibuf_i_ifu_valid,
  output logic                     ibuf_o_ifu_ready,
  input  logic [PC_W-1:0]          ibuf_i_pc,
  input  logic [IR_W-1:0]          ibuf_i_ir,
  input  logic                     ibuf_i_flush_req,
  output logic                     ibuf_o_exu_valid,
  input  logic                     ibuf_i_exu_ready,
  output logic [PC_W-1:0]          ibuf_o_pc,
  output logic [IR_W-1:0]          ibuf_o_ir,
  output logic                     ibuf_o_rv32,
  output logic [$clog2(DEPTH):0]   ibuf_o_count,
  output logic                     ibuf_o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [PC_W-1:0] last_pc_q, last_pc_d;
  logic [PC_W-1:0] head_pc;
  logic [IR_W-1:0] head_ir;
  logic empty, push, pop, byp;
  assign empty = count_q == '0;
  assign ibuf_o_ifu_ready = count_q != CW'(DEPTH);
`ifdef IFU_EXU_IBUF_BYPASS_EN
  assign byp = empty & ibuf_i_ifu_valid & ibuf_i_exu_ready & !ibuf_i_flush_req;
`else
  assign byp = 1'b0;
`endif
  assign push = ibuf_i_ifu_valid & ibuf_o_ifu_ready & !ibuf_i_flush_req & !byp;
  assign pop = !empty & !ibuf_i_flush_req & ibuf_i_exu_ready;
  ifu_exu_ibuf_entry_mem #(.DEPTH(DEPTH), .W(PC_W + IR_W)) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata ({ibuf_i_pc, ibuf_i_ir}),
    .raddr (rd_ptr_q),
    .rdata ({head_pc, head_ir})
  );
  // head view: bypassed pair, buffered head, or last head PC with a NOP when empty
  always_comb begin
    ibuf_o_exu_valid = (!empty | byp) & !ibuf_i_flush_req;
    ibuf_o_pc = byp ? ibuf_i_pc : empty ? last_pc_q : head_pc;
    ibuf_o_ir = byp ? ibuf_i_ir : empty ? NOP_IR : head_ir;
    ibuf_o_rv32 = is_rv32(ibuf_o_ir[1:0]);
    ibuf_o_count = count_q;
    ibuf_o_empty = empty;
  end
  // pointer and occupancy update; flush returns everything to the origin
  always_comb begin
    wr_ptr_d = ibuf_i_flush_req ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d = ibuf_i_flush_req ? '0 : rd_ptr_q + AW'(pop);
    count_d = ibuf_i_flush_req ? '0 : count_q + CW'(push) - CW'(pop);
    last_pc_d = ibuf_o_pc;
  end
  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      last_pc_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      last_pc_q <= last_pc_d;
    end
  end
endmodule

// File: tb/tb_ifu_exu_ibuf.sv
// tb_ifu_exu_ibuf: scoreboard bench for the IFU->EXU instruction buffer
module tb_ifu_exu_ibuf;
`ifdef IFU_EXU_IBUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0, rst_n = 1'b0;
  logic ifu_valid = 1'b0, ifu_ready, flush = 1'b0, exu_valid, exu_ready = 1'b0;
  logic rv32, empty;
  logic [31:0] i_pc = '0, i_ir = '0, o_pc, o_ir;
  logic [1:0] count;
  logic [63:0] q[$];
  int checks = 0, fails = 0;

  ifu_exu_ibuf dut (
    .clk(clk), .rst_n(rst_n),
    .ibuf_i_ifu_valid(ifu_valid), .ibuf_o_ifu_ready(ifu_ready),
    .ibuf_i_pc(i_pc), .ibuf_i_ir(i_ir), .ibuf_i_flush_req(flush),
    .ibuf_o_exu_valid(exu_valid), .ibuf_i_exu_ready(exu_ready),
    .ibuf_o_pc(o_pc), .ibuf_o_ir(o_ir), .ibuf_o_rv32(rv32),
    .ibuf_o_count(count), .ibuf_o_empty(empty)
  );

  always #5 clk = ~clk;

  // monitor: every EXU handshake must deliver the oldest expected pair
  always @(negedge clk) begin
    if (rst_n && exu_valid === 1'b1 && exu_ready) begin
      checks++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL pop_unexpected: got pc=%h ir=%h, scoreboard empty", o_pc, o_ir);
      end else begin
        logic [63:0] e;
        e = q.pop_front();
        if ({o_pc, o_ir} !== e || rv32 !== (e[1:0] == 2'b11)) begin
          fails++;
          $display("FAIL pop_data: got pc=%h ir=%h rv32=%b, want pc=%h ir=%h", o_pc, o_ir, rv32, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && q.size() != 0; k++) tick();
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries never reached EXU, want 0", q.size());
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({exu_valid, ifu_ready, empty, rv32, count, o_ir, o_pc} !== {1'b0, 1'b1, 1'b1, 1'b1, 2'd0, NOP, 32'h0}) begin
      fails++;
      $display("FAIL reset: v=%b rdy=%b e=%b rv32=%b cnt=%0d ir=%h pc=%h, want 0 1 1 1 0 %h 0", exu_valid, ifu_ready, empty, rv32, count, o_ir, o_pc, NOP);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({exu_valid, ifu_ready, count, o_ir} !== {1'b0, 1'b1, 2'd0, NOP}) begin
      fails++;
      $display("FAIL idle: v=%b rdy=%b cnt=%0d ir=%h, want 0 1 0 %h", exu_valid, ifu_ready, count, o_ir, NOP);
    end
  endtask

  task automatic test_fill_stall();
    exu_ready = 1'b0;
    ifu_valid = 1'b1; i_pc = 32'h100; i_ir = 32'h0050_0093; q.push_back({i_pc, i_ir});
    tick();
    i_pc = 32'h104; i_ir = 32'h00A0_0113; q.push_back({i_pc, i_ir});
    tick();
    checks++;
    if (count !== 2'd2 || ifu_ready !== 1'b0 || o_pc !== 32'h100) begin
      fails++;
      $display("FAIL full: cnt=%0d rdy=%b head=%h, want 2 0 100", count, ifu_ready, o_pc);
    end
    i_pc = 32'h108; i_ir = 32'h0000_0013;
    tick();
    checks++;
    if (count !== 2'd2 || o_pc !== 32'h100) begin
      fails++;
      $display("FAIL full_reject: cnt=%0d head=%h, want 2 100", count, o_pc);
    end
    ifu_valid = 1'b0; exu_ready = 1'b1;
    drain();
    tick();
    checks++;
    if (empty !== 1'b1 || exu_valid !== 1'b0 || o_pc !== 32'h104 || o_ir !== NOP) begin
      fails++;
      $display("FAIL empty_hold: e=%b v=%b pc=%h ir=%h, want 1 0 104 %h", empty, exu_valid, o_pc, o_ir, NOP);
    end
  endtask

  task automatic test_streaming();
    exu_ready = 1'b1; ifu_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      i_pc = 32'h200 + 32'(4 * i); i_ir = 32'h13 + 32'(i << 7); q.push_back({i_pc, i_ir});
      tick();
      checks++;
      if (count !== (BYP ? 2'd0 : 2'd1) || ifu_ready !== 1'b1) begin
        fails++;
        $display("FAIL stream_count[%0d]: cnt=%0d rdy=%b, want %0d 1", i, count, ifu_ready, BYP ? 0 : 1);
      end
    end
    ifu_valid = 1'b0;
    drain();
  endtask

  task automatic test_flush();
    exu_ready = 1'b0; ifu_valid = 1'b1;
    i_pc = 32'h280; i_ir = 32'h0010_0093; q.push_back({i_pc, i_ir});
    tick();
    i_pc = 32'h284; i_ir = 32'h0020_0093; q.push_back({i_pc, i_ir});
    tick();
    flush = 1'b1; exu_ready = 1'b1; i_pc = 32'h300; i_ir = 32'h0030_0093;
    #1;
    checks++;
    if (exu_valid !== 1'b0 || count !== 2'd2) begin
      fails++;
      $display("FAIL flush_mask: v=%b cnt=%0d, want 0 2", exu_valid, count);
    end
    tick();
    q.delete();
    flush = 1'b0; ifu_valid = 1'b0; exu_ready = 1'b0;
    checks++;
    if (count !== 2'd0 || ifu_ready !== 1'b1 || exu_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_clear: cnt=%0d rdy=%b v=%b, want 0 1 0", count, ifu_ready, exu_valid);
    end
    flush = 1'b1; ifu_valid = 1'b1; exu_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (count !== 2'd0 || exu_valid !== 1'b0) begin
        fails++;
        $display("FAIL flush_held[%0d]: cnt=%0d v=%b, want 0 0", i, count, exu_valid);
      end
    end
    flush = 1'b0; i_pc = 32'h400; i_ir = 32'h0040_0093; q.push_back({i_pc, i_ir});
    tick();
    ifu_valid = 1'b0;
    drain();
  endtask

  task automatic test_rv32();
    exu_ready = 1'b0; ifu_valid = 1'b1;
    i_pc = 32'h600; i_ir = 32'h0000_4501; q.push_back({i_pc, i_ir});
    tick();
    checks++;
    if (rv32 !== 1'b0 || o_ir !== 32'h4501) begin
      fails++;
      $display("FAIL rv16: rv32=%b ir=%h, want 0 4501", rv32, o_ir);
    end
    exu_ready = 1'b1; i_pc = 32'h604; i_ir = 32'h0000_0013; q.push_back({i_pc, i_ir});
    tick();
    ifu_valid = 1'b0;
    checks++;
    if (rv32 !== 1'b1 || o_pc !== 32'h604 || count !== 2'd1) begin
      fails++;
      $display("FAIL rv32: rv32=%b pc=%h cnt=%0d, want 1 604 1", rv32, o_pc, count);
    end
    drain();
  endtask

  task automatic test_bypass();
    tick();
    ifu_valid = 1'b1; exu_ready = 1'b1; i_pc = 32'h500; i_ir = 32'h0050_0093; q.push_back({i_pc, i_ir});
    #1;
    checks++;
    if (exu_valid !== BYP || (BYP && o_pc !== 32'h500) || count !== 2'd0) begin
      fails++;
      $display("FAIL bypass_same: v=%b pc=%h cnt=%0d, want %b %h 0", exu_valid, o_pc, count, BYP, BYP ? 32'h500 : o_pc);
    end
    tick();
    ifu_valid = 1'b0;
    checks++;
    if (exu_valid !== !BYP || count !== (BYP ? 2'd0 : 2'd1) || (!BYP && o_pc !== 32'h500)) begin
      fails++;
      $display("FAIL bypass_next: v=%b pc=%h cnt=%0d, want %b 500 %0d", exu_valid, o_pc, count, !BYP, BYP ? 0 : 1);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    exu_ready = 1'b0; ifu_valid = 1'b1; i_pc = 32'h700; i_ir = 32'h0070_0093; q.push_back({i_pc, i_ir});
    tick();
    ifu_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    q.delete();
    checks++;
    if ({count, exu_valid, ifu_ready, o_pc, o_ir} !== {2'd0, 1'b0, 1'b1, 32'h0, NOP}) begin
      fails++;
      $display("FAIL reset_mid: cnt=%0d v=%b rdy=%b pc=%h ir=%h, want 0 0 1 0 %h", count, exu_valid, ifu_ready, o_pc, o_ir, NOP);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_fill_stall();
    test_streaming();
    test_flush();
    test_rv32();
    test_bypass();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
